// File: rtl/dual_issue_scheduler_pkg.sv
// Shared definitions for the dual-issue scheduler slice.
// Holds the MIPS opcode/funct encodings used by the per-slot classifier,
// the scheduler FSM state type, and a small opcode helper.
// Optional feature macro used elsewhere in this slice: SCHED_PERF_EN.
package dual_issue_scheduler_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;

  typedef enum logic {
    ST_PAIR   = 1'b0,
    ST_SPLIT1 = 1'b1
  } sched_state_e;

  // Immediate ALU group (addi .. lui) occupies opcodes 0x08-0x0F.
  function automatic logic is_imm_alu(input logic [5:0] op);
    return (op[5:3] == 3'b001);
  endfunction

endpackage

// File: rtl/dual_issue_scheduler_if.sv
// Bundle between the IF/ID stage and the dual-issue scheduler.
// Signals:
//   instrd, instrd2  slot0 / slot1 instruction words (32'b0 = bubble)
//   ex_memread       instruction in EX is a load
//   ex_rt            destination register of that load
//   flush            redirect/kill, cancels the pair held in IF/ID
//   issue0, issue1   slot enters ID/EX this cycle
//   stalld, stallf   hold IF/ID, hold PC
//   split_active     scheduler is in the second half of a split pair
//   perf_dual/perf_split/perf_stall  present only with SCHED_PERF_EN
// Modports: master = pipeline side, slave = scheduler.
interface dual_issue_scheduler_if #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
);

  logic [31:0]     instrd;
  logic [31:0]     instrd2;
  logic            ex_memread;
  logic [RA_W-1:0] ex_rt;
  logic            flush;
  logic            issue0;
  logic            issue1;
  logic            stalld;
  logic            stallf;
  logic            split_active;

`ifdef SCHED_PERF_EN
  logic [CNT_W-1:0] perf_dual;
  logic [CNT_W-1:0] perf_split;
  logic [CNT_W-1:0] perf_stall;

  modport master (
    output instrd, instrd2, ex_memread, ex_rt, flush,
    input  issue0, issue1, stalld, stallf, split_active,
    input  perf_dual, perf_split, perf_stall
  );

  modport slave (
    input  instrd, instrd2, ex_memread, ex_rt, flush,
    output issue0, issue1, stalld, stallf, split_active,
    output perf_dual, perf_split, perf_stall
  );
`else
  // Keeps CNT_W referenced when the counters are compiled out.
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;

  modport master (
    output instrd, instrd2, ex_memread, ex_rt, flush,
    input  issue0, issue1, stalld, stallf, split_active
  );

  modport slave (
    input  instrd, instrd2, ex_memread, ex_rt, flush,
    output issue0, issue1, stalld, stallf, split_active
  );
`endif

endinterface

// File: rtl/dual_issue_scheduler_instr_class.sv
// instr_class: combinational classifier for one issue slot.
// Ports:
//   instr   in   32     instruction word (32'b0 = bubble)
//   dest    out  RA_W   written register, 0 when none
//   src_a   out  RA_W   first read register (rs), 0 when none
//   src_b   out  RA_W   second read register (rt), meaningful when uses_b
//   uses_b  out  1      src_b is read
//   is_mem  out  1      load or store
//   is_ctl  out  1      branch or jump
//   is_load out  1      load
//   valid   out  1      non-zero word
module instr_class
  import dual_issue_scheduler_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic [31:0]     instr,
  output logic [RA_W-1:0] dest,
  output logic [RA_W-1:0] src_a,
  output logic [RA_W-1:0] src_b,
  output logic            uses_b,
  output logic            is_mem,
  output logic            is_ctl,
  output logic            is_load,
  output logic            valid
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;

  assign op    = instr[31:26];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign funct = instr[5:0];
  assign valid = |instr;

  always_comb begin
    dest    = '0;
    src_a   = '0;
    src_b   = RA_W'(rt);
    uses_b  = 1'b0;
    is_mem  = 1'b0;
    is_ctl  = 1'b0;
    is_load = 1'b0;

    if (valid) begin
      src_a = RA_W'(rs);
      case (op)
        OP_RTYPE: begin
          uses_b = 1'b1;
          if ((funct == FN_JR) || (funct == FN_JALR)) begin
            is_ctl = 1'b1;
          end else begin
            dest = RA_W'(rd);
          end
        end
        OP_LW: begin
          dest    = RA_W'(rt);
          is_mem  = 1'b1;
          is_load = 1'b1;
        end
        OP_SW: begin
          uses_b = 1'b1;
          is_mem = 1'b1;
        end
        OP_BEQ, OP_BNE: begin
          uses_b = 1'b1;
          is_ctl = 1'b1;
        end
        OP_BLEZ, OP_BGTZ: begin
          is_ctl = 1'b1;
        end
        OP_J, OP_JAL: begin
          // Absolute jumps read no register; clearing src_a avoids false hazards.
          src_a  = '0;
          is_ctl = 1'b1;
        end
        default: begin
          if (is_imm_alu(op)) begin
            dest = RA_W'(rt);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/dual_issue_scheduler.sv
// dual_issue_scheduler: issue controller beside the IF/ID register.
// Examines the instruction pair (slot0 = instrd, slot1 = instrd2) and per
// cycle issues both, slot0 only, slot1 only or nothing; drives the IF/ID
// stall (stalld) and PC stall (stallf). A pair that cannot issue together
// is sequenced over two cycles (PAIR -> SPLIT1 -> PAIR).
// Ports:
//   clk    in  pipeline clock, rising edge
//   rst_n  in  asynchronous active-low reset; all outputs 0 while low
//   bus    slave modport of dual_issue_scheduler_if (see that file)
// Optional feature: SCHED_PERF_EN adds saturating perf_dual, perf_split,
// perf_stall counters to the bus.
module dual_issue_scheduler
  import dual_issue_scheduler_pkg::*;
#(
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  dual_issue_scheduler_if.slave   bus
);

  logic [RA_W-1:0] dest0, src_a0, src_b0;
  logic [RA_W-1:0] dest1, src_a1, src_b1;
  logic            uses_b0, is_mem0, is_ctl0, is_load0, valid0;
  logic            uses_b1, is_mem1, is_ctl1, is_load1, valid1;

  instr_class #(.RA_W(RA_W)) u_class0 (
    .instr   (bus.instrd),
    .dest    (dest0),
    .src_a   (src_a0),
    .src_b   (src_b0),
    .uses_b  (uses_b0),
    .is_mem  (is_mem0),
    .is_ctl  (is_ctl0),
    .is_load (is_load0),
    .valid   (valid0)
  );

  instr_class #(.RA_W(RA_W)) u_class1 (
    .instr   (bus.instrd2),
    .dest    (dest1),
    .src_a   (src_a1),
    .src_b   (src_b1),
    .uses_b  (uses_b1),
    .is_mem  (is_mem1),
    .is_ctl  (is_ctl1),
    .is_load (is_load1),
    .valid   (valid1)
  );

  // Load flags are not needed for pairing: the D-port check uses is_mem.
  logic unused_load;
  assign unused_load = is_load0 | is_load1 | is_ctl0;

  // ---------------------------------------------------------------- hazards
  logic both_valid;
  logic raw_hit, waw_hit, mem_hit, ctl_hit, conflict;
  logic ld_active, lu0, lu1;

  assign both_valid = valid0 & valid1;

  assign raw_hit = both_valid && (dest0 != '0) &&
                   ((src_a1 == dest0) || (uses_b1 && (src_b1 == dest0)));
  assign waw_hit = both_valid && (dest0 != '0) && (dest0 == dest1);
  assign mem_hit = both_valid & is_mem0 & is_mem1;
  assign ctl_hit = both_valid & is_ctl1;
  assign conflict = raw_hit | waw_hit | mem_hit | ctl_hit;

  assign ld_active = bus.ex_memread && (bus.ex_rt != '0);
  assign lu0 = ld_active && valid0 &&
               ((src_a0 == bus.ex_rt) || (uses_b0 && (src_b0 == bus.ex_rt)));
  assign lu1 = ld_active && valid1 &&
               ((src_a1 == bus.ex_rt) || (uses_b1 && (src_b1 == bus.ex_rt)));

  // ---------------------------------------------------------------- FSM
  sched_state_e state, state_n;
  logic issue0, issue1, stall, lu_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_PAIR;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    issue0   = 1'b0;
    issue1   = 1'b0;
    stall    = 1'b0;
    lu_stall = 1'b0;

    if (!rst_n) begin
      state_n = ST_PAIR;
    end else if (bus.flush) begin
      state_n = ST_PAIR;
    end else begin
      case (state)
        ST_PAIR: begin
          if (lu0 || lu1) begin
            stall    = 1'b1;
            lu_stall = 1'b1;
          end else if (conflict) begin
            issue0  = 1'b1;
            stall   = 1'b1;
            state_n = ST_SPLIT1;
          end else begin
            issue0 = valid0;
            issue1 = valid1;
          end
        end
        ST_SPLIT1: begin
          if (lu1) begin
            stall    = 1'b1;
            lu_stall = 1'b1;
          end else begin
            issue1  = 1'b1;
            state_n = ST_PAIR;
          end
        end
        default: begin
          state_n = ST_PAIR;
        end
      endcase
    end
  end

  assign bus.issue0       = issue0;
  assign bus.issue1       = issue1;
  assign bus.stalld       = stall;
  assign bus.stallf       = stall;
  assign bus.split_active = rst_n && (state == ST_SPLIT1);

  // ---------------------------------------------------------------- counters
`ifdef SCHED_PERF_EN
  logic [CNT_W-1:0] cnt_dual, cnt_split, cnt_stall;
  logic             ev_split;

  assign ev_split = (state == ST_PAIR) && (state_n == ST_SPLIT1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_dual  <= '0;
      cnt_split <= '0;
      cnt_stall <= '0;
    end else begin
      if (issue0 && issue1 && (cnt_dual != '1)) begin
        cnt_dual <= cnt_dual + CNT_W'(1);
      end
      if (ev_split && (cnt_split != '1)) begin
        cnt_split <= cnt_split + CNT_W'(1);
      end
      if (lu_stall && (cnt_stall != '1)) begin
        cnt_stall <= cnt_stall + CNT_W'(1);
      end
    end
  end

  assign bus.perf_dual  = cnt_dual;
  assign bus.perf_split = cnt_split;
  assign bus.perf_stall = cnt_stall;
`else
  // Keeps CNT_W referenced when the counters are compiled out.
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Directed self-checking bench for dual_issue_scheduler.
// Each step drives an instruction pair, pushes the expected
// {issue0, issue1, stalld, stallf, split_active} into a queue, and the
// sample at the following negedge pops and compares it.
module tb_dual_issue_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

  dual_issue_scheduler_if #(.RA_W(5), .CNT_W(32)) bus ();

  dual_issue_scheduler #(.RA_W(5), .CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [31:0] addu(input logic [4:0] rd, input logic [4:0] rs,
                                       input logic [4:0] rt);
    return {6'h00, rs, rt, rd, 5'd0, 6'h21};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Drive one pair, queue the expectation, compare at the next negedge.
  task automatic apply(input string tag, input logic [31:0] i0, input logic [31:0] i1,
                       input logic mr, input logic [4:0] ert, input logic fl,
                       input logic [4:0] e);
    logic [4:0] obs;
    logic [4:0] expv;
    bus.instrd     = i0;
    bus.instrd2    = i1;
    bus.ex_memread = mr;
    bus.ex_rt      = ert;
    bus.flush      = fl;
    exp_q.push_back(e);
    @(negedge clk);
    obs  = {bus.issue0, bus.issue1, bus.stalld, bus.stallf, bus.split_active};
    expv = exp_q.pop_front();
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed i0/i1/sd/sf/sp=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef SCHED_PERF_EN
  task automatic chk_cnt(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask
`endif

  logic [31:0] ind0, ind1, raw1, lu_a, lu_b, ld1, st1, beq1, addi1;

  initial begin
    ind0  = addu(5'd1, 5'd2, 5'd3);
    ind1  = addu(5'd4, 5'd5, 5'd6);
    raw1  = addu(5'd4, 5'd1, 5'd6);
    lu_a  = addu(5'd4, 5'd2, 5'd3);
    lu_b  = addu(5'd5, 5'd6, 5'd7);
    ld1   = itype(6'h23, 5'd2, 5'd1, 16'd0);
    st1   = itype(6'h2B, 5'd5, 5'd3, 16'd4);
    beq1  = itype(6'h04, 5'd4, 5'd5, 16'd8);
    addi1 = itype(6'h09, 5'd4, 5'd1, 16'd5);

    // Reset: outputs forced low even with a valid pair present
    apply("reset", ind0, ind1, 1'b0, 5'd0, 1'b0, 5'b00000);
`ifdef SCHED_PERF_EN
    chk_cnt("perf_dual_rst", bus.perf_dual, 32'd0);
    chk_cnt("perf_split_rst", bus.perf_split, 32'd0);
    chk_cnt("perf_stall_rst", bus.perf_stall, 32'd0);
`endif
    tick();
    rst_n = 1'b1;

    apply("indep_a", ind0, ind1, 1'b0, 5'd0, 1'b0, 5'b11000); tick();
    apply("indep_b", ind0, ind1, 1'b0, 5'd0, 1'b0, 5'b11000); tick();
    apply("raw_c1", ind0, raw1, 1'b0, 5'd0, 1'b0, 5'b10110); tick();
    apply("raw_c2", ind0, raw1, 1'b0, 5'd0, 1'b0, 5'b01001); tick();
    apply("indep_after_split", ind0, ind1, 1'b0, 5'd0, 1'b0, 5'b11000); tick();
    apply("loaduse_1", lu_a, lu_b, 1'b1, 5'd2, 1'b0, 5'b00110); tick();
    apply("loaduse_2", lu_a, lu_b, 1'b1, 5'd2, 1'b0, 5'b00110); tick();
    apply("loaduse_release", lu_a, lu_b, 1'b0, 5'd2, 1'b0, 5'b11000);
`ifdef SCHED_PERF_EN
    chk_cnt("perf_dual", bus.perf_dual, 32'd3);
    chk_cnt("perf_split", bus.perf_split, 32'd1);
    chk_cnt("perf_stall", bus.perf_stall, 32'd2);
`endif
    tick();

    // Load into $0 never stalls
    apply("load_r0", addu(5'd4, 5'd0, 5'd3), lu_b, 1'b1, 5'd0, 1'b0, 5'b11000); tick();

    apply("mem_c1", ld1, st1, 1'b0, 5'd0, 1'b0, 5'b10110); tick();
    apply("mem_c2", ld1, st1, 1'b0, 5'd0, 1'b0, 5'b01001); tick();

    // Bubbles
    apply("bubble0", 32'd0, ind1, 1'b0, 5'd0, 1'b0, 5'b01000); tick();
    apply("bubble1", ind0, 32'd0, 1'b0, 5'd0, 1'b0, 5'b10000); tick();
    apply("bubble_both", 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'b00000); tick();
    apply("bubble_ld", ld1, 32'd0, 1'b0, 5'd0, 1'b0, 5'b10000); tick();
    apply("bubble0_ctl", 32'd0, beq1, 1'b0, 5'd0, 1'b0, 5'b01000); tick();

    // Control in slot1 splits
    apply("ctl_c1", ind0, beq1, 1'b0, 5'd0, 1'b0, 5'b10110); tick();
    apply("ctl_c2", ind0, beq1, 1'b0, 5'd0, 1'b0, 5'b01001); tick();

    // Same destination splits; flush during SPLIT1 cancels slot1
    apply("waw_c1", ind0, addi1, 1'b0, 5'd0, 1'b0, 5'b10110); tick();
    apply("flush_split", ind0, addi1, 1'b0, 5'd0, 1'b1, 5'b00001); tick();
    apply("after_flush", ind0, ind1, 1'b0, 5'd0, 1'b0, 5'b11000); tick();

    // Load-use on slot1 while in SPLIT1
    apply("lu_split_c1", ind0, raw1, 1'b0, 5'd0, 1'b0, 5'b10110); tick();
    apply("lu_split_stall", ind0, raw1, 1'b1, 5'd6, 1'b0, 5'b00111); tick();
    apply("lu_split_go", ind0, raw1, 1'b0, 5'd6, 1'b0, 5'b01001); tick();

    // Flush beats load-use and conflict in PAIR
    apply("flush_pair", ind0, raw1, 1'b1, 5'd2, 1'b1, 5'b00000); tick();

    // Reset in SPLIT1 returns straight to PAIR
    apply("rst_split_c1", ind0, raw1, 1'b0, 5'd0, 1'b0, 5'b10110); tick();
    rst_n = 1'b0;
    apply("rst_in_split", ind0, raw1, 1'b0, 5'd0, 1'b0, 5'b00000); tick();
    rst_n = 1'b1;
    apply("rst_resplit_c1", ind0, raw1, 1'b0, 5'd0, 1'b0, 5'b10110); tick();
    apply("rst_resplit_c2", ind0, raw1, 1'b0, 5'd0, 1'b0, 5'b01001); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
